// File: rtl/comparator_seq.sv
// Multi-cycle magnitude comparator, one CHUNK-bit slice per clock, MSB first.
// Ports: clk, rst_n, start, signed_mode, A, B in; busy, done, EQ/LT/GT out.
module comparator_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] EQ,
  output logic [WIDTH-1:0] LT,
  output logic [WIDTH-1:0] GT
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] TOP = IW'(NCHUNK - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sm_q, sm_d;
  logic             done_q, done_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic             gt_q, gt_d;

  logic [CHUNK-1:0] ca, cb;

  // Select the active slice; in signed mode the top slice gets its
  // sign bit flipped so an unsigned compare orders it correctly.
  always_comb begin
    ca = '0;
    cb = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_q == IW'(i)) begin
        ca = a_q[i*CHUNK +: CHUNK];
        cb = b_q[i*CHUNK +: CHUNK];
      end
    end
    if (sm_q && (idx_q == TOP)) begin
      ca[CHUNK-1] = ~ca[CHUNK-1];
      cb[CHUNK-1] = ~cb[CHUNK-1];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sm_d    = sm_q;
    done_d  = 1'b0;
    eq_d    = eq_q;
    lt_d    = lt_q;
    gt_d    = gt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          sm_d    = signed_mode;
          idx_d   = TOP;
          state_d = RUN;
        end
      end
      RUN: begin
        if (ca != cb) begin
          lt_d    = (ca < cb);
          gt_d    = (ca > cb);
          eq_d    = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (idx_q == '0) begin
          eq_d    = 1'b1;
          lt_d    = 1'b0;
          gt_d    = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sm_q    <= 1'b0;
      done_q  <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sm_q    <= sm_d;
      done_q  <= done_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign EQ   = {{(WIDTH-1){1'b0}}, eq_q};
  assign LT   = {{(WIDTH-1){1'b0}}, lt_q};
  assign GT   = {{(WIDTH-1){1'b0}}, gt_q};

endmodule

// File: tb/tb_comparator_seq.sv
// Directed bench for comparator_seq: 32/8 and 16/4 instances.
// Ports: none; drives both DUTs from one clock and reset.
module tb_comparator_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        s0, sm0;
  logic [31:0] a0, b0;
  logic        busy0, done0;
  logic [31:0] eq0, lt0, gt0;

  logic        s1, sm1;
  logic [15:0] a1, b1;
  logic        busy1, done1;
  logic [15:0] eq1, lt1, gt1;

  comparator_seq #(.WIDTH(32), .CHUNK(8)) u_dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (s0),
    .signed_mode(sm0),
    .A          (a0),
    .B          (b0),
    .busy       (busy0),
    .done       (done0),
    .EQ         (eq0),
    .LT         (lt0),
    .GT         (gt0)
  );

  comparator_seq #(.WIDTH(16), .CHUNK(4)) u_dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (s1),
    .signed_mode(sm1),
    .A          (a1),
    .B          (b1),
    .busy       (busy1),
    .done       (done1),
    .EQ         (eq1),
    .LT         (lt1),
    .GT         (gt1)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic tsel = 1'b0;

  logic        c_busy, c_done;
  logic [31:0] c_eq, c_lt, c_gt;
  assign c_busy = tsel ? busy1 : busy0;
  assign c_done = tsel ? done1 : done0;
  assign c_eq   = tsel ? {16'h0, eq1} : eq0;
  assign c_lt   = tsel ? {16'h0, lt1} : lt0;
  assign c_gt   = tsel ? {16'h0, gt1} : gt0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic st, input logic [31:0] a,
                     input logic [31:0] b, input logic sm);
    if (tsel) begin
      s1 = st; a1 = a[15:0]; b1 = b[15:0]; sm1 = sm;
    end else begin
      s0 = st; a0 = a; b0 = b; sm0 = sm;
    end
  endtask

  // Issue start; returns #1 after the sampling edge.
  task automatic go(input logic now, input logic [31:0] a,
                    input logic [31:0] b, input logic sm);
    if (!now) @(negedge clk);
    drv(1'b1, a, b, sm);
    @(posedge clk);
    #1;
    drv(1'b0, a, b, sm);
  endtask

  // Count cycles to done; optionally poke start and new operands mid-run.
  task automatic wait_done(input string tag, input int lat,
                           input logic e, input logic l,
                           input logic g, input int poke_at);
    int cnt = 0;
    int bc = 0;
    while (!c_done && cnt < 12) begin
      if (c_busy) bc++;
      if (cnt == poke_at) drv(1'b1, 32'h0, 32'hFFFFFFFF, 1'b1);
      else drv(1'b0, 32'h0, 32'hFFFFFFFF, 1'b1);
      @(posedge clk);
      #1;
      cnt++;
    end
    drv(1'b0, 32'h0, 32'hFFFFFFFF, 1'b1);
    chk({tag, "_lat"}, cnt, lat);
    chk({tag, "_busycyc"}, bc, lat);
    chk({tag, "_busy"}, {31'h0, c_busy}, 32'h0);
    chk({tag, "_eq"}, c_eq, {31'h0, e});
    chk({tag, "_lt"}, c_lt, {31'h0, l});
    chk({tag, "_gt"}, c_gt, {31'h0, g});
  endtask

  initial begin
    int nd;
    rst_n = 1'b0;
    s0 = 0; sm0 = 0; a0 = '0; b0 = '0;
    s1 = 0; sm1 = 0; a1 = '0; b1 = '0;
    #23;
    chk("rst_busy0", {31'h0, busy0}, 32'h0);
    chk("rst_done0", {31'h0, done0}, 32'h0);
    chk("rst_res0", eq0 | lt0 | gt0, 32'h0);
    chk("rst_busy1", {31'h0, busy1}, 32'h0);
    chk("rst_res1", {16'h0, eq1 | lt1 | gt1}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    tsel = 1'b0;
    go(1'b1, 32'h12345678, 32'h12345678, 1'b0);
    wait_done("eq_u", 4, 1, 0, 0, -1);
    go(1'b0, 32'h80000000, 32'h7FFFFFFF, 1'b0);
    wait_done("msb_u", 1, 0, 0, 1, -1);
    go(1'b0, 32'h80000000, 32'h7FFFFFFF, 1'b1);
    wait_done("msb_s", 1, 0, 1, 0, -1);
    go(1'b0, 32'h00000100, 32'h00000200, 1'b0);
    wait_done("lt3_u", 3, 0, 1, 0, -1);
    go(1'b1, 32'hFFFFFF01, 32'hFFFFFF80, 1'b1);
    wait_done("b2b_s", 4, 0, 1, 0, -1);

    go(1'b0, 32'h11223344, 32'h11223344, 1'b0);
    wait_done("mid", 4, 1, 0, 0, 1);
    nd = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (done0 || busy0) nd++;
    end
    chk("mid_nodone", nd, 0);
    chk("mid_hold", eq0, 32'h1);

    go(1'b0, 32'hA0000000, 32'hA0000000, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'h0, busy0}, 32'h0);
    chk("arst_done", {31'h0, done0}, 32'h0);
    chk("arst_res", eq0 | lt0 | gt0, 32'h0);
    nd = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (done0 || busy0) nd++;
    end
    chk("arst_quiet", nd, 0);
    @(negedge clk);
    rst_n = 1'b1;
    go(1'b1, 32'h00000005, 32'h00000003, 1'b0);
    wait_done("post_rst", 4, 0, 0, 1, -1);

    tsel = 1'b1;
    go(1'b0, 32'h0000FFFF, 32'h0000FFFE, 1'b1);
    wait_done("w16_s4", 4, 0, 0, 1, -1);
    go(1'b0, 32'h00007FFF, 32'h00008000, 1'b1);
    wait_done("w16_s1", 1, 0, 0, 1, -1);
    go(1'b0, 32'h00007FFF, 32'h00008000, 1'b0);
    wait_done("w16_u1", 1, 0, 1, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
